// File: rtl/inv_square_scaler_pipe_pkg.sv
// inv_square_scaler_pipe_pkg: nibble width and the GF(2^4) square-scale map with its inverse.
package inv_square_scaler_pipe_pkg;

   localparam int NIBBLE_W = 4;

   function automatic logic [NIBBLE_W-1:0] inv_sq_scale_nib(input logic [NIBBLE_W-1:0] x);
      return {x[2] ^ x[1] ^ x[0], x[3] ^ x[0], x[1] ^ x[0], x[0]};
   endfunction

   // Forward map; the pipe never uses it, it exists for reference models.
   function automatic logic [NIBBLE_W-1:0] sq_scale_nib(input logic [NIBBLE_W-1:0] y);
      return {y[2] ^ y[0], y[3] ^ y[1], y[1] ^ y[0], y[0]};
   endfunction

endpackage

// File: rtl/inv_square_scaler_nib.sv
// inv_square_scaler_nib: combinational inverse square-scale map of one nibble.
module inv_square_scaler_nib
   import inv_square_scaler_pipe_pkg::*;
(
   input  logic [NIBBLE_W-1:0] x_i,
   output logic [NIBBLE_W-1:0] y_o
);

   assign y_o = inv_sq_scale_nib(x_i);

endmodule

// File: rtl/inv_square_scaler_pipe.sv
// inv_square_scaler_pipe: two-share inverse square-scaler, two valid/ready stages
// with a mask refresh on the stage-1 to stage-2 transfer.
module inv_square_scaler_pipe
   import inv_square_scaler_pipe_pkg::*;
#(
   parameter int NIBBLES = 8
) (
   input  logic                        ClkxCI,
   input  logic                        RstxRBI,
   input  logic                        InValidxSI,
   output logic                        InReadyxSO,
   input  logic [NIBBLE_W*NIBBLES-1:0] Share0xDI,
   input  logic [NIBBLE_W*NIBBLES-1:0] Share1xDI,
   input  logic [NIBBLE_W*NIBBLES-1:0] RandxDI,
   output logic                        OutValidxSO,
   input  logic                        OutReadyxSI,
   output logic [NIBBLE_W*NIBBLES-1:0] Share0xDO,
   output logic [NIBBLE_W*NIBBLES-1:0] Share1xDO,
   output logic                        BusyxSO
);

   localparam int W = NIBBLE_W * NIBBLES;

   logic         v1_q, v1_d, v2_q, v2_d;
   logic [W-1:0] s1_0_q, s1_0_d, s1_1_q, s1_1_d;
   logic [W-1:0] s2_0_q, s2_0_d, s2_1_q, s2_1_d;
   logic [W-1:0] map0, map1;
   logic         adv2, ld1, ld2;

   // Each share is mapped on its own; the shares are never combined.
   for (genvar i = 0; i < NIBBLES; i++) begin : g_nib
      inv_square_scaler_nib u_nib0 (
         .x_i(Share0xDI[NIBBLE_W*i +: NIBBLE_W]),
         .y_o(map0[NIBBLE_W*i +: NIBBLE_W])
      );
      inv_square_scaler_nib u_nib1 (
         .x_i(Share1xDI[NIBBLE_W*i +: NIBBLE_W]),
         .y_o(map1[NIBBLE_W*i +: NIBBLE_W])
      );
   end

   assign adv2       = ~v2_q | OutReadyxSI;
   assign ld2        = v1_q & adv2;
   assign InReadyxSO = ~v1_q | adv2;
   assign ld1        = InValidxSI & InReadyxSO;

   always_comb begin
      v1_d   = ld1 ? 1'b1 : (ld2 ? 1'b0 : v1_q);
      v2_d   = ld2 ? 1'b1 : (OutReadyxSI ? 1'b0 : v2_q);
      s1_0_d = ld1 ? map0 : s1_0_q;
      s1_1_d = ld1 ? map1 : s1_1_q;
      // Same mask on both shares keeps their XOR intact.
      s2_0_d = ld2 ? s1_0_q ^ RandxDI : s2_0_q;
      s2_1_d = ld2 ? s1_1_q ^ RandxDI : s2_1_q;
   end

   always_ff @(posedge ClkxCI) begin
      if (!RstxRBI) begin
         v1_q   <= 1'b0;
         v2_q   <= 1'b0;
         s1_0_q <= '0;
         s1_1_q <= '0;
         s2_0_q <= '0;
         s2_1_q <= '0;
      end else begin
         v1_q   <= v1_d;
         v2_q   <= v2_d;
         s1_0_q <= s1_0_d;
         s1_1_q <= s1_1_d;
         s2_0_q <= s2_0_d;
         s2_1_q <= s2_1_d;
      end
   end

   assign OutValidxSO = v2_q;
   assign Share0xDO   = s2_0_q;
   assign Share1xDO   = s2_1_q;
   assign BusyxSO     = v1_q | v2_q;

endmodule
